// File: rtl/acia_tx.sv
// Purpose : ACIA-style transmit-only UART with a CPU register interface (8N1, LSB first).
// Latency : start bit appears on o_tx 2 cycles after the holding-register write access when idle.
// Backpres: single holding register; a write while it is full is dropped and flagged as OVR.
//
// Ports:
//   i_clk      master clock, all state changes on its rising edge
//   i_reset_n  asynchronous active-low reset
//   i_data     CPU write data
//   i_rs       register select (0 = control/status, 1 = TX holding)
//   i_wr_n     active-low write strobe, edge-detected (one access per strobe)
//   i_rd_n     active-low read strobe, edge-detected for side effects
//   o_data     combinational read data, 8'h00 when not reading
//   o_tx       registered serial output, idle high
//   o_irq_n    registered active-low interrupt, asserted when IE and TDRE
module acia_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_wr_n,
    input  logic       i_rd_n,
    output logic [7:0] o_data,
    output logic       o_tx,
    output logic       o_irq_n
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [BW-1:0]   r_baud, w_baud_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [7:0]      r_hold, w_hold_nxt;
    logic            r_tdre, w_tdre_nxt;
    logic            r_ovr, w_ovr_nxt;
    logic            r_ie, w_ie_nxt;
    logic            r_wr_d, r_rd_d;
    logic            r_tx, w_tx_nxt;
    logic            r_irq_n;

    logic            w_wr_acc, w_rd_acc;
    logic            w_hold_wr, w_ctrl_wr, w_stat_rd;
    logic            w_baud_end;
    logic            w_xfer;
    logic [7:0]      w_status;

    // An access is the first cycle a strobe is seen low after being seen high.
    assign w_wr_acc   = r_wr_d & ~i_wr_n;
    assign w_rd_acc   = r_rd_d & ~i_rd_n;
    assign w_hold_wr  = w_wr_acc & i_rs;
    assign w_ctrl_wr  = w_wr_acc & ~i_rs;
    assign w_stat_rd  = w_rd_acc & ~i_rs;
    assign w_baud_end = (r_baud == BAUD_LAST);

    assign w_status = {5'b00000, r_ovr, (r_state != S_IDLE), r_tdre};

    // Shifter FSM: next state, counters, shift register and the holding transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_xfer      = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!r_tdre) begin
                    w_xfer      = 1'b1;
                    w_shift_nxt = r_hold;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Pending byte goes straight into a new start bit: no idle gap.
                    if (!r_tdre) begin
                        w_xfer      = 1'b1;
                        w_shift_nxt = r_hold;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // o_tx is registered from the next-state view so it lines up with r_state.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // CPU-visible registers.
    always_comb begin
        w_hold_nxt = r_hold;
        w_tdre_nxt = r_tdre;
        w_ovr_nxt  = r_ovr;
        w_ie_nxt   = r_ie;

        // A write coinciding with a transfer lands in the slot being vacated.
        if (w_hold_wr && (r_tdre || w_xfer)) begin
            w_hold_nxt = i_data;
            w_tdre_nxt = 1'b0;
        end else if (w_xfer) begin
            w_tdre_nxt = 1'b1;
        end

        // Overrun set beats a coincident status-read clear.
        if (w_hold_wr && !r_tdre && !w_xfer) begin
            w_ovr_nxt = 1'b1;
        end else if (w_stat_rd) begin
            w_ovr_nxt = 1'b0;
        end

        if (w_ctrl_wr) begin
            w_ie_nxt = i_data[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= 8'h00;
            r_hold  <= 8'h00;
            r_tdre  <= 1'b1;
            r_ovr   <= 1'b0;
            r_ie    <= 1'b0;
            r_wr_d  <= 1'b1;
            r_rd_d  <= 1'b1;
            r_tx    <= 1'b1;
            r_irq_n <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_hold  <= w_hold_nxt;
            r_tdre  <= w_tdre_nxt;
            r_ovr   <= w_ovr_nxt;
            r_ie    <= w_ie_nxt;
            r_wr_d  <= i_wr_n;
            r_rd_d  <= i_rd_n;
            r_tx    <= w_tx_nxt;
            // Built from next-cycle IE/TDRE so the flop tracks the registers exactly.
            r_irq_n <= ~(w_ie_nxt & w_tdre_nxt);
        end
    end

    always_comb begin
        o_data = 8'h00;
        if (!i_rd_n && !i_rs) begin
            o_data = w_status;
        end
    end

    assign o_tx    = r_tx;
    assign o_irq_n = r_irq_n;

endmodule

// File: tb/tb_acia_tx.sv
// Purpose : self-checking bench for acia_tx using a frame-timeline reference model.
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_acia_tx;

    localparam int C = 4;

    logic       i_clk;
    logic       i_reset_n;
    logic [7:0] i_data;
    logic       i_rs;
    logic       i_wr_n;
    logic       i_rd_n;
    logic [7:0] o_data;
    logic       o_tx;
    logic       o_irq_n;

    acia_tx #(.CLKS_PER_BIT(C)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_data    (i_data),
        .i_rs      (i_rs),
        .i_wr_n    (i_wr_n),
        .i_rd_n    (i_rd_n),
        .o_data    (o_data),
        .o_tx      (o_tx),
        .o_irq_n   (o_irq_n)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus one frame on a cycle timeline.
    int         m_cyc    = 0;
    bit         m_active = 1'b0;
    int         m_fstart = 0;
    logic [7:0] m_fdata  = 8'h00;
    logic [7:0] m_hold   = 8'h00;
    bit         m_tdre   = 1'b1;
    bit         m_ovr    = 1'b0;
    bit         m_ie     = 1'b0;
    bit         m_prev_wr = 1'b1;
    bit         m_prev_rd = 1'b1;

    function automatic bit covers(input int m);
        return m_active && (m >= m_fstart) && (m < m_fstart + 10 * C);
    endfunction

    function automatic logic exp_tx(input int m);
        int k;
        if (!covers(m)) return 1'b1;
        k = (m - m_fstart) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_fdata[k-1];
        return 1'b1;
    endfunction

    always @(posedge i_clk) begin
        bit wacc, racc, hw, cw, sr, xfer;
        logic [7:0] oldh;
        if (!i_reset_n) begin
            m_active  = 1'b0;
            m_hold    = 8'h00;
            m_tdre    = 1'b1;
            m_ovr     = 1'b0;
            m_ie      = 1'b0;
            m_prev_wr = 1'b1;
            m_prev_rd = 1'b1;
        end else begin
            wacc = m_prev_wr && !i_wr_n;
            racc = m_prev_rd && !i_rd_n;
            hw   = wacc && i_rs;
            cw   = wacc && !i_rs;
            sr   = racc && !i_rs;
            // A pending byte starts a frame as soon as no frame occupies the next cycle.
            xfer = !m_tdre && !covers(m_cyc + 1);
            oldh = m_hold;
            if (hw && (m_tdre || xfer)) begin
                m_hold = i_data;
                m_tdre = 1'b0;
                if (sr) m_ovr = 1'b0;
            end else if (hw) begin
                m_ovr = 1'b1;
            end else begin
                if (xfer) m_tdre = 1'b1;
                if (sr) m_ovr = 1'b0;
            end
            if (xfer) begin
                m_active = 1'b1;
                m_fstart = m_cyc + 1;
                m_fdata  = oldh;
            end
            if (cw) m_ie = i_data[0];
            m_prev_wr = i_wr_n;
            m_prev_rd = i_rd_n;
        end
        m_cyc = m_cyc + 1;
    end

    always @(negedge i_clk) begin
        logic       e_tx;
        logic       e_irq;
        logic [7:0] e_dat;
        if (!i_reset_n) begin
            chk("tx_in_reset", o_tx, 1);
            chk("irq_in_reset", o_irq_n, 1);
        end else begin
            e_tx  = exp_tx(m_cyc);
            e_irq = !(m_ie && m_tdre);
            e_dat = 8'h00;
            if (!i_rd_n && !i_rs) e_dat = {5'b00000, m_ovr, covers(m_cyc), m_tdre};
            chk("tx", o_tx, e_tx);
            chk("irq_n", o_irq_n, e_irq);
            chk("rd_data", o_data, e_dat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic cpu_wr(input logic rs, input logic [7:0] d, input int width);
        i_rs   = rs;
        i_data = d;
        i_wr_n = 1'b0;
        tick(width);
        i_wr_n = 1'b1;
        tick(1);
    endtask

    task automatic cpu_rd(input logic rs, output logic [7:0] d);
        i_rs   = rs;
        i_rd_n = 1'b0;
        @(negedge i_clk);
        d = o_data;
        tick(1);
        i_rd_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [9:0] pat;
        int op;

        i_reset_n = 1'b0;
        i_data    = 8'h00;
        i_rs      = 1'b0;
        i_wr_n    = 1'b1;
        i_rd_n    = 1'b1;
        tick(3);
        i_reset_n = 1'b1;
        tick(2);

        // Reset state.
        chk("reset_tx", o_tx, 1);
        chk("reset_irq_n", o_irq_n, 1);
        cpu_rd(1'b0, s);
        chk("reset_status", s, 8'h01);
        cpu_rd(1'b1, s);
        chk("reset_rd_hold", s, 8'h00);

        // 8'h55 from idle, status held on the bus through the frame.
        pat = 10'b1010101010;
        cpu_wr(1'b1, 8'h55, 1);
        i_rs   = 1'b0;
        i_rd_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            chk("frame55_bit", o_tx, pat[k]);
            chk("frame55_busy", o_data, 8'h03);
            repeat (3) @(negedge i_clk);
        end
        tick(1);
        i_rd_n = 1'b1;
        tick(4);

        // A3 then 0F during the A3 start bit: contiguous frames.
        cpu_wr(1'b1, 8'hA3, 1);
        cpu_wr(1'b1, 8'h0F, 1);
        cpu_rd(1'b0, s);
        chk("a3_0f_status", s, 8'h02);
        tick(85);
        cpu_rd(1'b0, s);
        chk("a3_0f_done", s, 8'h01);

        // Overrun: 33 dropped, OVR cleared by the first status read.
        cpu_wr(1'b1, 8'h11, 1);
        cpu_wr(1'b1, 8'h22, 1);
        cpu_wr(1'b1, 8'h33, 1);
        cpu_rd(1'b0, s);
        chk("ovr_status", s, 8'h06);
        cpu_rd(1'b0, s);
        chk("ovr_cleared", s, 8'h02);
        tick(85);

        // Interrupt enable and TDRE interplay.
        cpu_wr(1'b0, 8'h01, 1);
        chk("irq_enabled_idle", o_irq_n, 0);
        i_rs   = 1'b1;
        i_data = 8'h5A;
        i_wr_n = 1'b0;
        tick(1);
        i_wr_n = 1'b1;
        @(negedge i_clk);
        chk("irq_hold_full", o_irq_n, 1);
        @(negedge i_clk);
        chk("irq_after_xfer", o_irq_n, 0);
        tick(1);
        cpu_wr(1'b0, 8'h00, 1);
        chk("irq_disabled", o_irq_n, 1);
        tick(45);

        // Long write strobe is one access.
        cpu_wr(1'b1, 8'h7E, 10);
        cpu_rd(1'b0, s);
        chk("long_strobe_status", s, 8'h03);
        tick(45);
        cpu_rd(1'b0, s);
        chk("long_strobe_done", s, 8'h01);

        // Reset during data bit 3 of 8'hB6 (bit 3 is 0).
        cpu_wr(1'b1, 8'hB6, 1);
        tick(17);
        chk("b6_bit3", o_tx, 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("async_reset_tx", o_tx, 1);
        tick(2);
        i_reset_n = 1'b1;
        tick(1);
        cpu_rd(1'b0, s);
        chk("post_reset_status", s, 8'h01);
        cpu_wr(1'b1, 8'hC4, 1);
        tick(45);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                cpu_wr(1'b1, 8'($urandom), $urandom_range(1, 3));
            end else if (op == 4) begin
                cpu_wr(1'b0, 8'($urandom), 1);
            end else if (op <= 6) begin
                cpu_rd(1'b0, s);
            end else if (op == 7) begin
                cpu_rd(1'b1, s);
            end else begin
                tick($urandom_range(1, 30));
            end
        end
        tick(90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
